bcd_subtractor_seq: RTL and testbench

BCD_SUBTRACTOR_SEQ -- requirements
Module: bcd_subtractor_seq

---
 rtl/bcd_subtractor_seq.sv | 184 ++++++++++++++++++
 tb/tb_bcd_subtractor_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_subtractor_seq.sv
// Sequential digit-serial BCD subtractor: DIFF = |A - B| in BCD, NEG = (A < B).
// Optional invalid-nibble check is compiled in with `define BCD_DIGIT_CHECK_EN.
module bcd_subtractor_seq #(
    parameter int DIGITS = 2
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  Start,
    input  logic [4*DIGITS-1:0]   A,
    input  logic [4*DIGITS-1:0]   B,
    output logic [4*DIGITS-1:0]   DIFF,
    output logic                  NEG,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        FIX,
        DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [W-1:0]       a_reg;
    logic [W-1:0]       b_reg;
    logic [IDX_W-1:0]   idx;
    logic               borrow;

    logic [3:0]         a_dig;
    logic [3:0]         b_dig;
    logic signed [4:0]  t;
    logic [3:0]         d;
    logic               borrow_out;
    logic               last;
    logic               invalid;

    // Result digits enter at the top and slide down, so after DIGITS steps
    // the first (least-significant) digit sits in the bottom nibble.
    function automatic logic [W-1:0] shift_in(input logic [W-1:0] cur,
                                              input logic [3:0]   dig);
        logic [W-1:0] r;
        r = cur >> 4;
        r[W-1 -: 4] = dig;
        return r;
    endfunction

`ifdef BCD_DIGIT_CHECK_EN
    always_comb begin
        invalid = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (A[i*4 +: 4] > 4'd9 || B[i*4 +: 4] > 4'd9)
                invalid = 1'b1;
        end
    end
`else
    assign invalid = 1'b0;
`endif

    // One digit step: SUB works on the captured operands, FIX on 0 - DIFF.
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no
        // path through the case statement can leave it unassigned (a latch).
        a_dig = 4'd0;
        b_dig = 4'd0;
        case (state)
            SUB: begin
                a_dig = a_reg[3:0];
                b_dig = b_reg[3:0];
            end
            FIX: begin
                a_dig = 4'd0;
                b_dig = DIFF[3:0];
            end
            default: ;
        endcase
        t          = $signed({1'b0, a_dig}) - $signed({1'b0, b_dig})
                   - $signed({4'b0000, borrow});
        borrow_out = t[4];
        d          = t[4] ? (t[3:0] + 4'd10) : t[3:0];
        last       = (idx == IDX_W'(DIGITS - 1));
    end

    always_comb begin
        next_state = state;
        Busy       = (state != IDLE);
        Done       = (state == DONE);
        case (state)
            IDLE: begin
                if (Start)
                    next_state = SUB;
            end
            SUB: begin
`ifdef BCD_DIGIT_CHECK_EN
                // A rejected operand pair skips arithmetic: Done after edge 1.
                if (Error)
                    next_state = DONE;
                else
`endif
                if (last)
                    next_state = borrow_out ? FIX : DONE;
            end
            FIX: begin
                if (last)
                    next_state = DONE;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clock) begin
        if (!Resetn)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            a_reg  <= '0;
            b_reg  <= '0;
            DIFF   <= '0;
            NEG    <= 1'b0;
            Error  <= 1'b0;
            idx    <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        a_reg  <= A;
                        b_reg  <= B;
                        idx    <= '0;
                        borrow <= 1'b0;
                        Error  <= invalid;
                        if (invalid) begin
                            DIFF <= '0;
                            NEG  <= 1'b0;
                        end
                    end
                end
                SUB: begin
                    if (!Error) begin
                        a_reg <= a_reg >> 4;
                        b_reg <= b_reg >> 4;
                        DIFF  <= shift_in(DIFF, d);
                        if (last) begin
                            idx    <= '0;
                            borrow <= 1'b0;
                            NEG    <= borrow_out;
                        end else begin
                            idx    <= idx + IDX_W'(1);
                            borrow <= borrow_out;
                        end
                    end
                end
                FIX: begin
                    DIFF <= shift_in(DIFF, d);
                    if (last) begin
                        idx    <= '0;
                        borrow <= 1'b0;
                    end else begin
                        idx    <= idx + IDX_W'(1);
                        borrow <= borrow_out;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_subtractor_seq.sv
// Scoreboard bench for bcd_subtractor_seq: integer-arithmetic reference model,
// expected results queued at Start, popped by a monitor whenever Done is seen.
module tb_bcd_subtractor_seq;

    localparam int DIGITS = 2;
    localparam int W      = 4 * DIGITS;

    typedef struct {
        logic [W-1:0] diff;
        logic         neg;
        logic         err;
        int           done_cyc;
    } exp_t;

    logic         Clock;
    logic         Resetn;
    logic         Start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] DIFF;
    logic         NEG;
    logic         Busy;
    logic         Done;
    logic         Error;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];

    bcd_subtractor_seq #(.DIGITS(DIGITS)) dut (
        .Clock (Clock),
        .Resetn(Resetn),
        .Start (Start),
        .A     (A),
        .B     (B),
        .DIFF  (DIFF),
        .NEG   (NEG),
        .Busy  (Busy),
        .Done  (Done),
        .Error (Error)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--)
            r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int n);
        logic [W-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input int edge0);
        exp_t e;
        int   ia;
        int   ib;
        e.err = 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
        for (int i = 0; i < DIGITS; i++)
            if (av[i*4 +: 4] > 4'd9 || bv[i*4 +: 4] > 4'd9) e.err = 1'b1;
        if (e.err) begin
            e.diff     = '0;
            e.neg      = 1'b0;
            e.done_cyc = edge0 + 1;
            return e;
        end
`endif
        ia         = bcd2int(av);
        ib         = bcd2int(bv);
        e.neg      = (ia < ib);
        e.diff     = int2bcd(e.neg ? ib - ia : ia - ib);
        e.done_cyc = edge0 + (e.neg ? 2 * DIGITS : DIGITS);
        return e;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++)
            r[i*4 +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Monitor: every Done must match the oldest outstanding expectation.
    always @(negedge Clock) begin
        if (Resetn && Done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'(Done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("diff", 32'(DIFF), 32'(e.diff));
                check("neg", 32'(NEG), 32'(e.neg));
                check("error", 32'(Error), 32'(e.err));
                check("done_latency", 32'(cyc), 32'(e.done_cyc));
                check("busy_in_done", 32'(Busy), 32'd1);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (Busy && n < 50) begin
            @(negedge Clock);
            n++;
        end
        check("idle_timeout", 32'(Busy), 32'd0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge Clock);
            n++;
        end
        check("done_timeout", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit hold);
        wait_idle();
        @(negedge Clock);
        A     = av;
        B     = bv;
        Start = 1'b1;
        sb.push_back(model(av, bv, cyc + 1));
        if (!hold) begin
            @(negedge Clock);
            Start = 1'b0;
            A     = W'($urandom);
            B     = W'($urandom);
        end else begin
            // Start stays high and operands churn until Done is observed.
            for (int k = 0; k < 20; k++) begin
                @(negedge Clock);
                if (Done) break;
                A = W'($urandom);
                B = W'($urandom);
            end
            Start = 1'b0;
        end
        wait_drain();
    endtask

    initial begin
        Resetn = 1'b0;
        Start  = 1'b0;
        A      = '0;
        B      = '0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_diff", 32'(DIFF), 32'd0);
        check("rst_neg", 32'(NEG), 32'd0);
        check("rst_error", 32'(Error), 32'd0);
        Resetn = 1'b1;

        run_op(8'h45, 8'h27, 1'b0);
        run_op(8'h27, 8'h45, 1'b0);
        run_op(8'h00, 8'h99, 1'b0);
        run_op(8'h50, 8'h50, 1'b0);
        run_op(8'h99, 8'h00, 1'b0);
        run_op(8'h27, 8'h45, 1'b1);
        run_op(8'h61, 8'h08, 1'b1);

        // Reset sampled at edge 1 of 27-45 aborts with no Done pulse.
        wait_idle();
        @(negedge Clock);
        A     = 8'h27;
        B     = 8'h45;
        Start = 1'b1;
        @(negedge Clock);
        Start  = 1'b0;
        Resetn = 1'b0;
        @(negedge Clock);
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_done", 32'(Done), 32'd0);
        check("abort_diff", 32'(DIFF), 32'd0);
        check("abort_neg", 32'(NEG), 32'd0);
        Resetn = 1'b1;
        repeat (8) @(negedge Clock);
        run_op(8'h27, 8'h45, 1'b0);

`ifdef BCD_DIGIT_CHECK_EN
        run_op(8'h3A, 8'h01, 1'b0);
        run_op(8'h12, 8'hF3, 1'b0);
        run_op(8'h12, 8'h03, 1'b0);
`endif

        for (int i = 0; i < 40; i++)
            run_op(rand_bcd(), rand_bcd(), ($urandom_range(0, 3) == 0));

        // Results must hold while idle.
        begin
            logic [W-1:0] d0;
            logic         n0;
            d0 = DIFF;
            n0 = NEG;
            repeat (5) @(negedge Clock);
            check("hold_diff", 32'(DIFF), 32'(d0));
            check("hold_neg", 32'(NEG), 32'(n0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
